// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: word-read memory port plus the instruction handshake to decode.
// The master modport is the fetch unit; the slave modport is the memory/decode environment.
interface instr_fetch_if;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        instr_valid_o;
   logic [31:0] instr_data_o;
   logic [31:0] instr_pc_o;
   logic        instr_ready_i;

   modport master (
      output mem_req_o,
      output mem_addr_o,
      input  mem_gnt_i,
      input  mem_rvalid_i,
      input  mem_rdata_i,
      output instr_valid_o,
      output instr_data_o,
      output instr_pc_o,
      input  instr_ready_i
   );

   modport slave (
      input  mem_req_o,
      input  mem_addr_o,
      output mem_gnt_i,
      output mem_rvalid_i,
      output mem_rdata_i,
      input  instr_valid_o,
      input  instr_data_o,
      input  instr_pc_o,
      output instr_ready_i
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the fetch PC, issues credit-limited word reads, buffers words for decode.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirects park the unit in ST_FAULT until an aligned redirect.
module instr_fetch #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          FIFO_DEPTH      = 2,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 redirect_i,
   input  logic [31:0]          redirect_pc_i,
   instr_fetch_if.master        bus,
   output logic                 fetch_fault_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 2;

`ifdef FETCH_MISALIGN_CHECK_EN
   typedef enum logic [1:0] {ST_RESET, ST_FETCH, ST_FAULT} state_e;
`else
   typedef enum logic [1:0] {ST_RESET, ST_FETCH} state_e;
`endif

   state_e        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic          pend_q, pend_d;
   logic          pend_stale_q, pend_stale_d;
   logic [31:0]   pend_addr_q, pend_addr_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] disc_q, disc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [PW-1:0] wptr_q, wptr_d;

   logic [31:0]   fifo_data_q [FIFO_DEPTH];
   logic [31:0]   fifo_pc_q   [FIFO_DEPTH];

   logic [31:0]   redir_tgt;
   logic          redir_bad;
   logic          in_fetch;
   logic          pop;
   logic          push;
   logic          grant;
   logic          issue;
   logic [CW-1:0] credit;

   assign redir_tgt = redirect_pc_i & ~32'h3;
`ifdef FETCH_MISALIGN_CHECK_EN
   assign redir_bad     = |redirect_pc_i[1:0];
   assign fetch_fault_o = (state_q == ST_FAULT);
`else
   assign redir_bad     = 1'b0;
   assign fetch_fault_o = 1'b0;
`endif

   assign in_fetch = (state_q == ST_FETCH);
   assign pop      = (cnt_q != '0) & bus.instr_ready_i;

   // A word leaving this cycle frees its slot, which is what sustains one word per cycle.
   assign credit = cnt_q + outst_q + disc_q - CW'(pop);
   assign issue  = in_fetch && (outst_q < CW'(MAX_OUTSTANDING)) && (credit < CW'(FIFO_DEPTH));

   // A raised request is replayed from pend_* so it cannot move before it is granted.
   assign bus.mem_req_o  = pend_q | issue;
   assign bus.mem_addr_o = pend_q ? pend_addr_q : fetch_pc_q;
   assign grant          = bus.mem_req_o & bus.mem_gnt_i;
   assign push           = bus.mem_rvalid_i & (disc_q == '0) & ~redirect_i & in_fetch;

   assign bus.instr_valid_o = (cnt_q != '0);
   assign bus.instr_data_o  = bus.instr_valid_o ? fifo_data_q[rptr_q] : '0;
   assign bus.instr_pc_o    = bus.instr_valid_o ? fifo_pc_q[rptr_q]   : '0;

   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      resp_pc_d    = resp_pc_q;
      pend_d       = bus.mem_req_o & ~bus.mem_gnt_i;
      pend_addr_d  = bus.mem_addr_o;
      pend_stale_d = 1'b0;
      outst_d      = outst_q + CW'(grant) - CW'(bus.mem_rvalid_i);
      disc_d       = disc_q;
      cnt_d        = cnt_q;
      rptr_d       = rptr_q;
      wptr_d       = wptr_q;

      case (state_q)
         ST_RESET: state_d = ST_FETCH;
         ST_FETCH: state_d = ST_FETCH;
`ifdef FETCH_MISALIGN_CHECK_EN
         ST_FAULT: state_d = ST_FAULT;
`endif
         default:  state_d = ST_RESET;
      endcase

      if (redirect_i) begin
`ifdef FETCH_MISALIGN_CHECK_EN
         state_d = redir_bad ? ST_FAULT : ST_FETCH;
`else
         state_d = ST_FETCH;
`endif
         fetch_pc_d   = redir_tgt;
         resp_pc_d    = redir_tgt;
         pend_stale_d = pend_d;
         // Everything still in flight after this edge belongs to the old stream.
         disc_d       = outst_d;
         cnt_d        = '0;
         rptr_d       = '0;
         wptr_d       = '0;
      end else begin
         pend_stale_d = pend_d & pend_stale_q;
         if (grant && !pend_stale_q)
            fetch_pc_d = fetch_pc_q + 32'd4;
         if (!in_fetch)
            disc_d = outst_d;
         else
            disc_d = disc_q + CW'(grant & pend_stale_q)
                     - CW'(bus.mem_rvalid_i & (disc_q != '0));
         if (push) begin
            wptr_d    = wptr_q + 1'b1;
            resp_pc_d = resp_pc_q + 32'd4;
         end
         if (pop)
            rptr_d = rptr_q + 1'b1;
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q      <= ST_RESET;
         fetch_pc_q   <= RESET_PC;
         resp_pc_q    <= RESET_PC;
         pend_q       <= 1'b0;
         pend_stale_q <= 1'b0;
         pend_addr_q  <= RESET_PC;
         outst_q      <= '0;
         disc_q       <= '0;
         cnt_q        <= '0;
         rptr_q       <= '0;
         wptr_q       <= '0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         resp_pc_q    <= resp_pc_d;
         pend_q       <= pend_d;
         pend_stale_q <= pend_stale_d;
         pend_addr_q  <= pend_addr_d;
         outst_q      <= outst_d;
         disc_q       <= disc_d;
         cnt_q        <= cnt_d;
         rptr_q       <= rptr_d;
         wptr_q       <= wptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_data_q[wptr_q] <= bus.mem_rdata_i;
         fifo_pc_q[wptr_q]   <= resp_pc_q;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: memory model with random grant/latency, decode with random ready,
// and a PC-stream scoreboard; a second instance checks RESET_PC wrap-around.
module tb_instr_fetch;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        fault0, fault1;
   logic        redirect1;
   logic [31:0] redirect_pc1;

   instr_fetch_if bus0 ();
   instr_fetch_if bus1 ();

   instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2), .MAX_OUTSTANDING(2)) dut0 (
      .clk_i(clk), .rstn_i(rstn), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
      .bus(bus0.master), .fetch_fault_o(fault0));

   instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2), .MAX_OUTSTANDING(2)) dut1 (
      .clk_i(clk), .rstn_i(rstn), .redirect_i(redirect1), .redirect_pc_i(redirect_pc1),
      .bus(bus1.master), .fetch_fault_o(fault1));

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
   endfunction

   // memory model: in-order queue of granted addresses with the earliest cycle each may answer
   logic [31:0] mq_addr[$];
   int          mq_due[$];

   int          gnt_pct, lat_min, lat_max, rdy_pct, redir_pct;
   bit          f_redir;
   logic [31:0] f_redir_pc;

   logic [31:0] exp_pc;
   int          acc_cnt;
   logic [31:0] last_acc_pc;
   int          cyc;

   logic        s_req, s_iv, s_fault;
   logic [31:0] s_addr, s_id, s_ip;
   logic        p_hold, p_stall;
   logic [31:0] p_addr, p_id, p_ip;

   logic [31:0] q1_pcs[$];
   logic        r1_pend;
   logic [31:0] r1_addr;

   task automatic step();
      logic        rdy, gnt, redir, rv;
      logic [31:0] rpc, rd;
      @(negedge clk);
      cyc++;
      s_iv    = bus0.instr_valid_o;
      s_id    = bus0.instr_data_o;
      s_ip    = bus0.instr_pc_o;
      s_fault = fault0;
      if (p_stall) begin
         chk("hold_vld", {31'b0, s_iv}, 32'd1);
         chk("hold_pc", s_ip, p_ip);
         chk("hold_data", s_id, p_id);
      end
`ifndef FETCH_MISALIGN_CHECK_EN
      chk("fault_low", {31'b0, s_fault}, 32'd0);
`endif
      rdy = ($urandom_range(0, 99) < rdy_pct);
      bus0.instr_ready_i = rdy;
      #1;
      s_req  = bus0.mem_req_o;
      s_addr = bus0.mem_addr_o;
      if (p_hold) begin
         chk("req_hold", {31'b0, s_req}, 32'd1);
         chk("addr_hold", s_addr, p_addr);
      end
      if (s_req) chk("addr_align", {30'b0, s_addr[1:0]}, 32'd0);

      gnt   = ($urandom_range(0, 99) < gnt_pct);
      redir = f_redir || ($urandom_range(0, 99) < redir_pct);
      rpc   = f_redir ? f_redir_pc : 32'($urandom_range(0, 4095));
`ifdef FETCH_MISALIGN_CHECK_EN
      if (!f_redir) rpc = rpc & ~32'h3;
`endif
      rv = 1'b0;
      rd = $urandom;
      if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
         rv = 1'b1;
         rd = memf(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end

      // what the coming clock edge does, seen from decode and memory
      if (s_iv && rdy && !redir) begin
         chk("pc", s_ip, exp_pc);
         chk("data", s_id, memf(exp_pc));
         exp_pc      = exp_pc + 32'd4;
         last_acc_pc = s_ip;
         acc_cnt++;
      end
      if (redir) exp_pc = rpc & ~32'h3;
      if (s_req && gnt) begin
         mq_addr.push_back(s_addr);
         mq_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
         chk("outst_le_max", {31'b0, (mq_addr.size() <= 2)}, 32'd1);
      end
      p_hold  = s_req && !gnt;
      p_addr  = s_addr;
      p_stall = s_iv && !rdy && !redir;
      p_id    = s_id;
      p_ip    = s_ip;

      if (bus1.instr_valid_o && q1_pcs.size() < 3) begin
         q1_pcs.push_back(bus1.instr_pc_o);
         chk("wrap_data", bus1.instr_data_o, memf(bus1.instr_pc_o));
      end
      bus1.mem_gnt_i    = 1'b1;
      bus1.mem_rvalid_i = r1_pend;
      bus1.mem_rdata_i  = memf(r1_addr);
      r1_pend           = bus1.mem_req_o;
      r1_addr           = bus1.mem_addr_o;

      bus0.mem_gnt_i    = gnt;
      bus0.mem_rvalid_i = rv;
      bus0.mem_rdata_i  = rd;
      redirect          = redir;
      redirect_pc       = rpc;
   endtask

   task automatic wait_acc(input string tag, input logic [31:0] want);
      int a0 = acc_cnt;
      int n  = 0;
      while (acc_cnt == a0 && n < 40) begin
         step();
         n++;
      end
      if (acc_cnt == a0) chk({tag, "_timeout"}, 32'(acc_cnt - a0), 32'd1);
      else               chk(tag, last_acc_pc, want);
   endtask

   task automatic set_mode(input int g, input int lmin, input int lmax, input int r, input int rd);
      gnt_pct = g; lat_min = lmin; lat_max = lmax; rdy_pct = r; redir_pct = rd;
   endtask

   initial begin
      int          a0;
      int          n;
      logic [31:0] addr_a;
      rstn = 1'b0;
      redirect = 1'b0; redirect_pc = '0; redirect1 = 1'b0; redirect_pc1 = '0;
      bus0.mem_gnt_i = 1'b0; bus0.mem_rvalid_i = 1'b0; bus0.mem_rdata_i = '0; bus0.instr_ready_i = 1'b0;
      bus1.mem_gnt_i = 1'b0; bus1.mem_rvalid_i = 1'b0; bus1.mem_rdata_i = '0; bus1.instr_ready_i = 1'b1;
      f_redir = 1'b0; f_redir_pc = '0; exp_pc = '0; acc_cnt = 0; last_acc_pc = '0; cyc = 0;
      p_hold = 1'b0; p_stall = 1'b0; r1_pend = 1'b0; r1_addr = '0;
      set_mode(100, 1, 1, 100, 0);

      repeat (3) @(negedge clk);
      chk("rst_req", {31'b0, bus0.mem_req_o}, 32'd0);
      chk("rst_addr", bus0.mem_addr_o, 32'h0000_0000);
      chk("rst_vld", {31'b0, bus0.instr_valid_o}, 32'd0);
      chk("rst_data", bus0.instr_data_o, 32'd0);
      chk("rst_pc", bus0.instr_pc_o, 32'd0);
      chk("rst_fault", {31'b0, fault0}, 32'd0);
      chk("rst_addr1", bus1.mem_addr_o, 32'hFFFF_FFF8);
      rstn = 1'b1;

      // streaming with an always-grant, one-cycle memory
      step();
      chk("first_req", {31'b0, s_req}, 32'd1);
      chk("first_addr", s_addr, 32'h0000_0000);
      step();
      chk("lat_n1_vld", {31'b0, s_iv}, 32'd0);
      a0 = acc_cnt;
      repeat (10) step();
      chk("throughput", 32'(acc_cnt - a0), 32'd10);

      // decode stall: buffer fills, requests stop, then exactly two words drain
      set_mode(100, 1, 1, 0, 0);
      repeat (10) step();
      chk("stall_req", {31'b0, s_req}, 32'd0);
      chk("stall_vld", {31'b0, s_iv}, 32'd1);
      set_mode(0, 1, 1, 100, 0);
      a0 = acc_cnt;
      repeat (4) step();
      chk("stall_fill", 32'(acc_cnt - a0), 32'd2);
      set_mode(100, 1, 1, 100, 0);
      repeat (6) step();

      // redirect with two reads in flight
      set_mode(100, 3, 3, 100, 0);
      n = 0;
      while (mq_addr.size() != 2 && n < 20) begin step(); n++; end
      chk("two_outst", 32'(mq_addr.size()), 32'd2);
      f_redir = 1'b1; f_redir_pc = 32'h100;
      step();
      f_redir = 1'b0;
      wait_acc("redir_pc", 32'h100);

      // redirect while a request is stalled without grant
      set_mode(0, 1, 1, 100, 0);
      n = 0;
      step();
      while (!s_req && n < 20) begin step(); n++; end
      addr_a = s_addr;
      f_redir = 1'b1; f_redir_pc = 32'h200;
      step();
      f_redir = 1'b0;
      repeat (3) begin
         step();
         chk("stall_addr", s_addr, addr_a);
      end
      set_mode(100, 1, 1, 100, 0);
      step();
      n = 0;
      step();
      while (!s_req && n < 20) begin step(); n++; end
      chk("next_addr", s_addr, 32'h200);
      wait_acc("redir2_pc", 32'h200);

`ifdef FETCH_MISALIGN_CHECK_EN
      f_redir = 1'b1; f_redir_pc = 32'h102;
      step();
      f_redir = 1'b0;
      repeat (3) step();
      chk("fault_set", {31'b0, s_fault}, 32'd1);
      chk("fault_req", {31'b0, s_req}, 32'd0);
      chk("fault_vld", {31'b0, s_iv}, 32'd0);
      f_redir = 1'b1; f_redir_pc = 32'h300;
      step();
      f_redir = 1'b0;
      step();
      chk("fault_clr", {31'b0, s_fault}, 32'd0);
      wait_acc("fault_exit_pc", 32'h300);
`else
      f_redir = 1'b1; f_redir_pc = 32'h102;
      step();
      f_redir = 1'b0;
      wait_acc("misalign_ignored", 32'h100);
`endif

      // random traffic, an asynchronous reset in the middle, more random traffic
      set_mode(70, 1, 4, 70, 3);
      repeat (750) step();
      #2 rstn = 1'b0;
      #1;
      chk("mid_rst_req", {31'b0, bus0.mem_req_o}, 32'd0);
      chk("mid_rst_vld", {31'b0, bus0.instr_valid_o}, 32'd0);
      chk("mid_rst_addr", bus0.mem_addr_o, 32'h0000_0000);
      mq_addr.delete(); mq_due.delete();
      redirect = 1'b0; bus0.mem_rvalid_i = 1'b0; bus0.mem_gnt_i = 1'b0;
      bus1.mem_rvalid_i = 1'b0;
      p_hold = 1'b0; p_stall = 1'b0; r1_pend = 1'b0; exp_pc = 32'h0;
      @(negedge clk);
      rstn = 1'b1;
      a0 = acc_cnt;
      repeat (750) step();
      chk("progress", {31'b0, (acc_cnt - a0 > 100)}, 32'd1);

      if (q1_pcs.size() < 3) begin
         chk("wrap_cnt", 32'(q1_pcs.size()), 32'd3);
      end else begin
         chk("wrap_pc0", q1_pcs[0], 32'hFFFF_FFF8);
         chk("wrap_pc1", q1_pcs[1], 32'hFFFF_FFFC);
         chk("wrap_pc2", q1_pcs[2], 32'h0000_0000);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
